timer_ctrl: RTL and testbench
=============================

# timer_ctrl

Control stage for the countdown timer. It sits directly upstream of the cascaded `mod10` digit counters (tens and ones) and drives their `data`, `loadn`, `clrn` and `enable` inputs. It turns start/stop button inputs into a load / run / pause / done sequence and paces counting with an internal prescaler. It watches the chain's terminal count to detect expiry.

## Interface
- `TICK_DIV`, 10: clock cycles per count tick (≥2).
- `ALARM_CYCLES`, 8: alarm pulse length in cycles (≥1; used only with the alarm feature).

- `clock` in 1: single clock, all logic on rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: start/resume/reload button, asynchronous level.
- `stop` in 1: pause/abort button, asynchronous level.
- `preset_tens` in 4: BCD preset, tens digit.
- `preset_ones` in 4: BCD preset, ones digit.
- `tc` in 1: high when the counter chain reads 00.
- `data_tens` out 4: load value to tens counter.
- `data_ones` out 4: load value to ones counter.
- `loadn` out 1: active-low synchronous load to counters.
- `clrn` out 1: active-low clear to counters.
- `enable` out 1: one-cycle count-down enable pulse.
- `running` out 1: high in RUN.
- `done` out 1: high in DONE.
- `alarm` out 1: expiry pulse (see Configuration).

## Operation
- Inputs `start`/`stop` pass through a 2-flop synchronizer, then a rising-edge detector. Only edges act; held levels do nothing further.
- Preset digits > 9 are clamped to 9. The clamped values are captured into `data_tens`/`data_ones` on the start edge that leaves IDLE or DONE. They hold otherwise.
- States: CLEAR, IDLE, LOAD, RUN, PAUSE, DONE.
  - CLEAR: `clrn`=0. Next state is IDLE.
  - IDLE: on a start edge, go to LOAD. If the captured preset is 00, go to DONE instead.
  - LOAD: `loadn`=0 for exactly one cycle. The prescaler is cleared. Next state is RUN.
  - RUN:
    - The prescaler counts 0..TICK_DIV-1 and wraps.
    - `enable`=1 for the one cycle where the prescaler equals TICK_DIV-1.
    - `tc` is ignored in the first RUN cycle after LOAD.
    - Afterwards, `tc`=1 forces `enable`=0 in that cycle and moves to DONE.
    - A stop edge moves to PAUSE; the prescaler value is held.
    - Start edges are ignored.
  - PAUSE: `enable`=0.
    - A start edge returns to RUN, and the prescaler resumes from its held value.
    - A stop edge aborts to CLEAR.
  - DONE: `done`=1.
    - A start edge recaptures the preset and goes to LOAD, or to DONE if the preset is 00.
    - A stop edge goes to CLEAR.
- If start and stop edges occur in the same cycle, stop wins.
- `tc` rising at the same time as a stop edge in RUN: DONE wins.

## Timing
- Reset values:
  - state CLEAR, `clrn`=0, `loadn`=1, `enable`=0
  - `running`=0, `done`=0, `alarm`=0
  - `data_tens`=`data_ones`=0
  - prescaler 0
- Reset asserted mid-operation returns to CLEAR on the next edge, regardless of state.
- After `reset` deasserts, there is one CLEAR cycle (`clrn`=0), then IDLE.
- Button latency: a button sampled high at edge k produces an edge at k+2 and the state change at k+2. `loadn` is low in the cycle after edge k+2.
- After LOAD, the first `enable` pulse occurs in RUN cycle TICK_DIV. Subsequent pulses come every TICK_DIV cycles.
- All outputs are registered or decoded from registered state. There are no combinational paths from `start`, `stop` or `tc` to outputs, except the `tc` gating of `enable`.

## Configuration
- `TIMER_CTRL_ALARM_EN` defined: `alarm`=1 for exactly ALARM_CYCLES cycles starting on the first DONE cycle, then 0 while in DONE. The alarm counter clears on leaving DONE and on reset.
- Not defined: `alarm` is tied to 0, there is no alarm counter, and ALARM_CYCLES is unused. All other behaviour is identical.

## Test plan
- Reset held 3 cycles, then released → `clrn`=0 during reset and for 1 cycle after, then 1. All other outputs at reset values. State IDLE.
- Preset 1/2, start pulse, TICK_DIV=10 → `loadn` low 1 cycle with data 1/2. `enable` pulses every 10 cycles. A bench model of the counters counts 12→0. `done`=1 the cycle after `tc` is seen, with no `enable` in that cycle.
- Run with preset 0/5; stop at the 2nd tick, wait 30 cycles, then start → no `enable` during PAUSE. The next `enable` arrives exactly the remaining-prescaler cycles after resume.
- Preset 0xA/0xF → data captured as 9/9. Preset 0/0 with start → direct to DONE with no LOAD.
- Start and stop edges in the same cycle during RUN → PAUSE. The same in PAUSE → CLEAR with `clrn`=0 for 1 cycle.
- With `TIMER_CTRL_ALARM_EN`, ALARM_CYCLES=8 → `alarm` high exactly 8 cycles from DONE entry. Without the macro, `alarm` stays 0 throughout. Reset asserted mid-RUN → CLEAR on the next edge.

Source files
------------

// File: rtl/timer_ctrl.sv
// Countdown timer control stage: button sync/edge detect, load/run/pause/done FSM, tick prescaler.
// Optional expiry alarm pulse enabled by defining TIMER_CTRL_ALARM_EN.
module timer_ctrl #(
    parameter int TICK_DIV     = 10,
    parameter int ALARM_CYCLES = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic       stop,
    input  logic [3:0] preset_tens,
    input  logic [3:0] preset_ones,
    input  logic       tc,
    output logic [3:0] data_tens,
    output logic [3:0] data_ones,
    output logic       loadn,
    output logic       clrn,
    output logic       enable,
    output logic       running,
    output logic       done,
    output logic       alarm
);
    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

    typedef enum logic [2:0] {
        S_CLEAR, S_IDLE, S_LOAD, S_RUN, S_PAUSE, S_DONE
    } state_t;

    state_t        state;
    logic [PW-1:0] presc;
    logic          first_run;
    logic [2:0]    start_sync;
    logic [2:0]    stop_sync;
    logic          start_edge;
    logic          stop_edge;
    logic [3:0]    tens_clamped;
    logic [3:0]    ones_clamped;
    logic          preset_zero;
    logic          tc_hit;

    // Bits [1:0] synchronize the button, bit [2] is the previous synchronized level.
    always_ff @(posedge clock) begin
        if (reset) begin
            start_sync <= 3'b000;
            stop_sync  <= 3'b000;
        end else begin
            start_sync <= {start_sync[1:0], start};
            stop_sync  <= {stop_sync[1:0], stop};
        end
    end

    assign start_edge   = start_sync[1] & ~start_sync[2];
    assign stop_edge    = stop_sync[1] & ~stop_sync[2];
    assign tens_clamped = (preset_tens > 4'd9) ? 4'd9 : preset_tens;
    assign ones_clamped = (preset_ones > 4'd9) ? 4'd9 : preset_ones;
    assign preset_zero  = (tens_clamped == 4'd0) && (ones_clamped == 4'd0);

    // Terminal count is not trusted in the first RUN cycle, while the chain settles after load.
    assign tc_hit  = (state == S_RUN) && tc && !first_run;
    assign enable  = (state == S_RUN) && (presc == PRESC_MAX) && !tc_hit;
    assign clrn    = (state != S_CLEAR);
    assign loadn   = (state != S_LOAD);
    assign running = (state == S_RUN);
    assign done    = (state == S_DONE);

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= S_CLEAR;
            presc     <= '0;
            first_run <= 1'b0;
            data_tens <= 4'd0;
            data_ones <= 4'd0;
        end else begin
            case (state)
                S_CLEAR: state <= S_IDLE;
                S_IDLE: begin
                    if (start_edge && !stop_edge) begin
                        data_tens <= tens_clamped;
                        data_ones <= ones_clamped;
                        state     <= preset_zero ? S_DONE : S_LOAD;
                    end
                end
                S_LOAD: begin
                    presc     <= '0;
                    first_run <= 1'b1;
                    state     <= S_RUN;
                end
                S_RUN: begin
                    first_run <= 1'b0;
                    if (tc_hit) begin
                        state <= S_DONE;
                    end else begin
                        presc <= (presc == PRESC_MAX) ? '0 : presc + PW'(1);
                        if (stop_edge) state <= S_PAUSE;
                    end
                end
                S_PAUSE: begin
                    if (stop_edge)       state <= S_CLEAR;
                    else if (start_edge) state <= S_RUN;
                end
                S_DONE: begin
                    if (stop_edge) begin
                        state <= S_CLEAR;
                    end else if (start_edge) begin
                        data_tens <= tens_clamped;
                        data_ones <= ones_clamped;
                        state     <= preset_zero ? S_DONE : S_LOAD;
                    end
                end
                default: state <= S_CLEAR;
            endcase
        end
    end

`ifdef TIMER_CTRL_ALARM_EN
    localparam int AW = $clog2(ALARM_CYCLES + 1);
    logic [AW-1:0] alarm_cnt;

    // Counter saturates at ALARM_CYCLES so the alarm stays low for the rest of DONE.
    always_ff @(posedge clock) begin
        if (reset || (state != S_DONE)) begin
            alarm_cnt <= '0;
        end else if (alarm_cnt != AW'(ALARM_CYCLES)) begin
            alarm_cnt <= alarm_cnt + AW'(1);
        end
    end

    assign alarm = (state == S_DONE) && (alarm_cnt < AW'(ALARM_CYCLES));
`else
    localparam int unused_alarm_cycles = ALARM_CYCLES;
    assign alarm = 1'b0;
`endif

endmodule

// File: tb/tb_timer_ctrl.sv
// Bench for timer_ctrl: directed button scenarios, a BCD counter-chain model,
// and an event scoreboard keyed on the cycle each output event appears.
module tb_timer_ctrl;
    localparam int TICK_DIV     = 10;
    localparam int ALARM_CYCLES = 8;
    localparam int W            = 28;

    localparam logic [3:0] T_LOAD    = 4'd1;
    localparam logic [3:0] T_EN      = 4'd2;
    localparam logic [3:0] T_DONE    = 4'd3;
    localparam logic [3:0] T_RUNOFF  = 4'd4;
    localparam logic [3:0] T_CLR     = 4'd5;
    localparam logic [3:0] T_ALM_ON  = 4'd6;
    localparam logic [3:0] T_ALM_OFF = 4'd7;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic [3:0] preset_tens = 4'd0;
    logic [3:0] preset_ones = 4'd0;
    logic       tc;
    logic [3:0] data_tens;
    logic [3:0] data_ones;
    logic       loadn;
    logic       clrn;
    logic       enable;
    logic       running;
    logic       done;
    logic       alarm;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [W-1:0] exp_q[$];

    timer_ctrl #(.TICK_DIV(TICK_DIV), .ALARM_CYCLES(ALARM_CYCLES)) dut (
        .clock(clk), .reset(reset), .start(start), .stop(stop),
        .preset_tens(preset_tens), .preset_ones(preset_ones), .tc(tc),
        .data_tens(data_tens), .data_ones(data_ones), .loadn(loadn),
        .clrn(clrn), .enable(enable), .running(running), .done(done),
        .alarm(alarm)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- mod10 tens/ones chain model ----------------
    logic [3:0] m_tens = 4'd0;
    logic [3:0] m_ones = 4'd0;
    assign tc = (m_tens == 4'd0) && (m_ones == 4'd0);

    always @(posedge clk) begin
        if (!clrn) begin
            m_tens <= 4'd0;
            m_ones <= 4'd0;
        end else if (!loadn) begin
            m_tens <= data_tens;
            m_ones <= data_ones;
        end else if (enable) begin
            if (m_ones == 4'd0) begin
                m_ones <= 4'd9;
                m_tens <= m_tens - 4'd1;
            end else begin
                m_ones <= m_ones - 4'd1;
            end
        end
    end

    // ---------------- scoreboard ----------------
    function automatic logic [W-1:0] ev(input logic [3:0] tag, input logic [7:0] d, input int c);
        logic [15:0] c16;
        c16 = c[15:0];
        return {tag, d, c16};
    endfunction

    task automatic push_ev(input logic [3:0] tag, input logic [7:0] d, input int c);
        exp_q.push_back(ev(tag, d, c));
    endtask

    task automatic check_ev(input logic [W-1:0] got);
        logic [W-1:0] want;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event got tag=%0d data=%h cyc=%0d, none expected",
                     got[27:24], got[23:16], got[15:0]);
        end else begin
            want = exp_q.pop_front();
            if (got !== want) begin
                errors++;
                $display("FAIL event got tag=%0d data=%h cyc=%0d expected tag=%0d data=%h cyc=%0d",
                         got[27:24], got[23:16], got[15:0], want[27:24], want[23:16], want[15:0]);
            end
        end
    endtask

    task automatic check(input string name, input logic [7:0] actual, input logic [7:0] required);
        checks++;
        if (actual !== required) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, actual, required);
        end
    endtask

    // ---------------- monitor ----------------
    logic done_prev = 1'b0;
    logic run_prev = 1'b0;
    logic alarm_prev = 1'b0;

    always @(negedge clk) begin
        if (!reset) begin
            if (!loadn)                 check_ev(ev(T_LOAD, {data_tens, data_ones}, cyc));
            if (enable)                 check_ev(ev(T_EN, 8'h00, cyc));
            if (done && !done_prev)     check_ev(ev(T_DONE, {data_tens, data_ones}, cyc));
            if (run_prev && !running)   check_ev(ev(T_RUNOFF, 8'h00, cyc));
            if (!clrn)                  check_ev(ev(T_CLR, 8'h00, cyc));
            if (alarm && !alarm_prev)   check_ev(ev(T_ALM_ON, 8'h00, cyc));
            if (!alarm && alarm_prev)   check_ev(ev(T_ALM_OFF, 8'h00, cyc));
        end
        done_prev  = done;
        run_prev   = running;
        alarm_prev = alarm;
    end

    // ---------------- driver tasks ----------------
    task automatic step_to(input int t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_alarm(input int c);
`ifdef TIMER_CTRL_ALARM_EN
        push_ev(T_ALM_ON, 8'h00, c);
        push_ev(T_ALM_OFF, 8'h00, c + ALARM_CYCLES);
`else
        if (c < 0) $display("negative cycle %0d", c);
`endif
    endtask

    task automatic press(input logic s_start, input logic s_stop, input int k0);
        start = s_start;
        stop  = s_stop;
        step_to(k0 + 2);
        start = 1'b0;
        stop  = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_clrn"}, {7'd0, clrn}, 8'h00);
        check({tag, "_loadn"}, {7'd0, loadn}, 8'h01);
        check({tag, "_enable"}, {7'd0, enable}, 8'h00);
        check({tag, "_running"}, {7'd0, running}, 8'h00);
        check({tag, "_done"}, {7'd0, done}, 8'h00);
        check({tag, "_alarm"}, {7'd0, alarm}, 8'h00);
        check({tag, "_data"}, {data_tens, data_ones}, 8'h00);
    endtask

    // ---------------- stimulus ----------------
    int k0;

    initial begin
        // Reset held for three cycles; one CLEAR cycle expected after release.
        repeat (3) begin
            @(negedge clk);
            check_reset_outputs("reset");
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        push_ev(T_CLR, 8'h00, cyc);
        step_to(cyc + 3);

        // Preset 12: load, 12 ticks every TICK_DIV cycles, DONE the cycle after tc.
        preset_tens = 4'd1;
        preset_ones = 4'd2;
        k0 = cyc;
        push_ev(T_LOAD, 8'h12, k0 + 3);
        for (int i = 0; i < 12; i++) push_ev(T_EN, 8'h00, k0 + 13 + TICK_DIV * i);
        push_ev(T_DONE, 8'h12, k0 + 125);
        push_ev(T_RUNOFF, 8'h00, k0 + 125);
        push_alarm(k0 + 125);
        press(1'b1, 1'b0, k0);
        step_to(k0 + 135);

        // Preset 05 from DONE: pause after the 2nd tick (prescaler held at 3), resume.
        preset_tens = 4'd0;
        preset_ones = 4'd5;
        k0 = cyc;
        push_ev(T_LOAD, 8'h05, k0 + 3);
        push_ev(T_EN, 8'h00, k0 + 13);
        push_ev(T_EN, 8'h00, k0 + 23);
        push_ev(T_RUNOFF, 8'h00, k0 + 27);
        push_ev(T_EN, 8'h00, k0 + 66);
        push_ev(T_EN, 8'h00, k0 + 76);
        push_ev(T_EN, 8'h00, k0 + 86);
        push_ev(T_DONE, 8'h05, k0 + 88);
        push_ev(T_RUNOFF, 8'h00, k0 + 88);
        push_alarm(k0 + 88);
        press(1'b1, 1'b0, k0);
        step_to(k0 + 24);
        press(1'b0, 1'b1, k0 + 24);
        step_to(k0 + 57);
        press(1'b1, 1'b0, k0 + 57);
        step_to(k0 + 100);

        // Preset A/F clamps to 99; start+stop in RUN pauses, start+stop in PAUSE clears.
        preset_tens = 4'hA;
        preset_ones = 4'hF;
        k0 = cyc;
        push_ev(T_LOAD, 8'h99, k0 + 3);
        push_ev(T_EN, 8'h00, k0 + 13);
        push_ev(T_RUNOFF, 8'h00, k0 + 18);
        push_ev(T_CLR, 8'h00, k0 + 23);
        press(1'b1, 1'b0, k0);
        step_to(k0 + 15);
        press(1'b1, 1'b1, k0 + 15);
        step_to(k0 + 20);
        press(1'b1, 1'b1, k0 + 20);
        step_to(k0 + 30);

        // Preset 00 from IDLE goes straight to DONE with no LOAD.
        preset_tens = 4'd0;
        preset_ones = 4'd0;
        k0 = cyc;
        push_ev(T_DONE, 8'h00, k0 + 3);
        push_alarm(k0 + 3);
        press(1'b1, 1'b0, k0);
        step_to(k0 + 15);

        // Preset 03 from DONE, then reset mid-RUN.
        preset_tens = 4'd0;
        preset_ones = 4'd3;
        k0 = cyc;
        push_ev(T_LOAD, 8'h03, k0 + 3);
        push_ev(T_EN, 8'h00, k0 + 13);
        press(1'b1, 1'b0, k0);
        step_to(k0 + 16);
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_reset_outputs("midrun_reset");
        @(posedge clk);
        #1;
        reset = 1'b0;
        push_ev(T_CLR, 8'h00, cyc);
        step_to(cyc + 6);

        while (exp_q.size() > 0) begin
            logic [W-1:0] want;
            want = exp_q.pop_front();
            checks++;
            errors++;
            $display("FAIL missing_event expected tag=%0d data=%h cyc=%0d, got nothing",
                     want[27:24], want[23:16], want[15:0]);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
